skolem_sweep_checker: RTL and testbench
=======================================

SKOLEM_SWEEP_CHECKER -- requirements
Module: skolem_sweep_checker

Interface
REQ-001 Parameter: N_IN, default 8, width of the universally quantified input vector driven to the Skolem function under test.
REQ-002 Parameter: LAT, default 0, Skolem-function latency in cycles (0 = combinational).
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: start  input  1  sweep request, sampled only in IDLE or DONE.
REQ-006 Port: abort  input  1  synchronous sweep cancel.
REQ-007 Port: sk_in  output  N_IN  assignment driven to the Skolem function inputs (i0 = bit 0).
REQ-008 Port: sk_out  input  1  Skolem function output bit.
REQ-009 Port: phi_vec  output  N_IN+1  full assignment {sk_q, sk_in} presented to the formula oracle.
REQ-010 Port: phi_ok  input  1  combinational oracle result for phi_vec; 1 = formula satisfied.
REQ-011 Port: busy  output  1  high in SETTLE and CHECK.
REQ-012 Port: done  output  1  high in DONE.
REQ-013 Port: pass  output  1  done AND fail_cnt == 0.
REQ-014 Port: fail_cnt  output  N_IN+1  count of failing assignments.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK, DONE.
REQ-016 IDLE/DONE with start=1: SHALL clear vec, fail_cnt, sk_q and the first-fail registers, then enter SETTLE.
REQ-017 SETTLE SHALL hold sk_in = vec for LAT+1 cycles; on its last cycle sk_q SHALL load sk_out, then the FSM enters CHECK.
REQ-018 CHECK SHALL last one cycle: phi_vec = {sk_q, vec}; if phi_ok=0, fail_cnt increments.
REQ-019 CHECK with vec = 2^N_IN-1 SHALL enter DONE; otherwise vec increments and the FSM returns to SETTLE.
REQ-020 Each assignment SHALL take exactly LAT+2 cycles; done SHALL rise 2^N_IN*(LAT+2) cycles after the start edge.
REQ-021 vec SHALL not wrap within a sweep; fail_cnt cannot overflow (max 2^N_IN fits in N_IN+1 bits).
REQ-022 start while busy SHALL be ignored.
REQ-023 abort=1 in SETTLE or CHECK SHALL enter IDLE next cycle with fail_cnt and vec frozen, and done=0.
REQ-024 abort has priority over start and over the CHECK update in the same cycle; abort in IDLE/DONE SHALL have no effect.
REQ-025 DONE SHALL persist, with outputs held, until start or reset.
REQ-026 sk_in and phi_vec SHALL be driven from registers only, with no combinational path from sk_out or phi_ok.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, vec=0, sk_in=0, sk_q=0, phi_vec=0, fail_cnt=0, busy=0, done=0, pass=0, and first-fail registers cleared.
REQ-028 Reset asserted mid-sweep SHALL discard all progress; a new start is required.

Configuration
REQ-029 With macro SKC_FIRST_FAIL_CAPTURE_EN defined, the block SHALL add outputs first_fail_valid (1 bit) and first_fail_vec (N_IN+1 bits), capturing phi_vec at the first CHECK with phi_ok=0 and holding it until next start or reset.
REQ-030 Without SKC_FIRST_FAIL_CAPTURE_EN, these ports and registers SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-031 N_IN=8, LAT=0, oracle always 1, start pulse -> done rises exactly 512 cycles later, pass=1, fail_cnt=0.
REQ-032 N_IN=8, LAT=2, oracle returns 0 only for phi_vec[7:0]=8'h35 -> done after 1024 cycles, fail_cnt=1, pass=0; first_fail_vec[7:0]=8'h35 when the macro is enabled.
REQ-033 Skolem model outputs 1, oracle = NOT phi_vec[8] -> fail_cnt=256, first_fail_vec=9'h100.
REQ-034 abort asserted during CHECK of vec=8'h10 -> IDLE next cycle, fail_cnt unchanged, done=0; subsequent start restarts at vec=0.
REQ-035 rst_n pulsed low asynchronously at vec=8'h80 -> all outputs zero before the next clock edge; start pressed during the sweep is ignored (busy stays 1, vec continues).

Source files
------------

// File: rtl/skolem_sweep_checker.sv
// Exhaustive Skolem-function checker: sweeps every input assignment, waits LAT+1 cycles, then
// asks an oracle whether {sk, vec} satisfies the formula. Optional SKC_FIRST_FAIL_CAPTURE_EN.
module skolem_sweep_checker #(
  parameter int unsigned N_IN = 8,
  parameter int unsigned LAT  = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] sk_in,
  input  logic            sk_out,
  output logic [N_IN:0]   phi_vec,
  input  logic            phi_ok,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   fail_cnt
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
  ,
  output logic            first_fail_valid,
  output logic [N_IN:0]   first_fail_vec
`endif
);

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  localparam int unsigned   CntW    = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LAT);
  localparam logic [N_IN-1:0] VecLast = '1;

  state_e          state_q, state_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            sk_q, sk_d;
  logic [N_IN:0]   fail_q, fail_d;
  logic [CntW-1:0] cnt_q, cnt_d;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
  logic            ffv_q, ffv_d;
  logic [N_IN:0]   ffvec_q, ffvec_d;
`endif

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    sk_d    = sk_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          vec_d   = '0;
          sk_d    = 1'b0;
          fail_d  = '0;
          cnt_d   = '0;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
          ffv_d   = 1'b0;
          ffvec_d = '0;
`endif
          state_d = StSettle;
        end
      end
      StSettle: begin
        // abort freezes everything, including a pending sk_q load
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          sk_d    = sk_out;
          cnt_d   = '0;
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StCheck: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          if (!phi_ok) begin
            fail_d = fail_q + 1'b1;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = {sk_q, vec_q};
            end
`endif
          end
          if (vec_q == VecLast) begin
            state_d = StDone;
          end else begin
            vec_d   = vec_q + 1'b1;
            state_d = StSettle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      sk_q    <= 1'b0;
      fail_q  <= '0;
      cnt_q   <= '0;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      sk_q    <= sk_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
`endif
    end
  end

  // Everything facing the Skolem function and oracle comes straight from flops.
  assign sk_in    = vec_q;
  assign phi_vec  = {sk_q, vec_q};
  assign busy     = (state_q == StSettle) || (state_q == StCheck);
  assign done     = (state_q == StDone);
  assign pass     = done && (fail_q == '0);
  assign fail_cnt = fail_q;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
`endif

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Bench for skolem_sweep_checker (N_IN=8, LAT=2): table of full sweeps plus abort/reset sequences.
module tb_skolem_sweep_checker;

  localparam int N   = 8;
  localparam int LAT = 2;
  localparam int P   = LAT + 2;

  logic         clk = 1'b0;
  logic         rst_n, start, abort;
  logic [N-1:0] sk_in;
  logic         sk_out;
  logic [N:0]   phi_vec;
  logic         phi_ok;
  logic         busy, done, pass;
  logic [N:0]   fail_cnt;
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
  logic         first_fail_valid;
  logic [N:0]   first_fail_vec;
`endif

  skolem_sweep_checker #(.N_IN(N), .LAT(LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .sk_in    (sk_in),
    .sk_out   (sk_out),
    .phi_vec  (phi_vec),
    .phi_ok   (phi_ok),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_cnt (fail_cnt)
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_valid (first_fail_valid),
    .first_fail_vec   (first_fail_vec)
`endif
  );

  always #5 clk = ~clk;

  int mode = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic [N:0] exp_q[$];

  function automatic logic skf(input int m, input logic [N-1:0] v);
    return (m == 2) ? 1'b1 : ^v;
  endfunction

  // Skolem function under test: LAT-stage pipeline
  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge clk) begin
    p1 <= skf(mode, sk_in);
    p2 <= p1;
  end
  assign sk_out = p2;

  always_comb begin
    phi_ok = 1'b1;
    case (mode)
      1: phi_ok = (phi_vec[7:0] != 8'h35);
      2: phi_ok = !phi_vec[8];
      3: phi_ok = (phi_vec[8] == ^phi_vec[7:0]) && (phi_vec[7:4] != 4'hA);
      default: phi_ok = 1'b1;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    exp_q.delete();
    for (int v = 0; v < (1 << N); v++) exp_q.push_back({skf(mode, N'(v)), N'(v)});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // j counts cycles after the start edge; CHECK of each assignment is the last of its P cycles
  task automatic run_cycles(input int from_j, input int to_j);
    logic [N:0] e;
    for (int j = from_j; j < to_j; j++) begin
      @(negedge clk);
      if (j % P == P - 1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("sweep_check", {busy, sk_in, phi_vec}, {1'b1, e[N-1:0], e});
      end
    end
  endtask

  typedef struct {
    int         mode;
    logic [N:0] fail;
    logic       pass;
    logic       ffv;
    logic [N:0] ffvec;
  } vec_t;
  vec_t tbl[4];

  initial begin
    tbl[0] = '{0, 9'd0,   1'b1, 1'b0, 9'h000};
    tbl[1] = '{1, 9'd1,   1'b0, 1'b1, 9'h035};
    tbl[2] = '{2, 9'd256, 1'b0, 1'b1, 9'h100};
    tbl[3] = '{3, 9'd16,  1'b0, 1'b1, 9'h0A0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    #1 chk("reset_outputs", {sk_in, phi_vec, fail_cnt, busy, done, pass}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, pass}, 3'b000);

    // abort during CHECK of vec 0x10, with start asserted in the same cycle
    mode = 2;
    do_start();
    run_cycles(0, 16 * P + LAT + 1);
    @(negedge clk);
    chk("pre_abort_cnt", 32'(fail_cnt), 32'd16);
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_check", {busy, done, pass, fail_cnt, sk_in}, {3'b000, 9'd16, 8'h10});
    repeat (3) @(negedge clk);
    chk("abort_stays_idle", {busy, done, sk_in}, {2'b00, 8'h10});

    // restart from 0, then abort in SETTLE of vec 2
    do_start();
    @(negedge clk);
    chk("restart_vec0", {busy, fail_cnt, sk_in}, {1'b1, 9'd0, 8'h00});
    run_cycles(1, 2 * P);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_settle", {busy, done, fail_cnt, sk_in}, {2'b00, 9'd2, 8'h02});
    exp_q.delete();

    // full sweeps, each started from IDLE or DONE
    for (int t = 0; t < 4; t++) begin
      mode = tbl[t].mode;
      do_start();
      run_cycles(0, (1 << N) * P);
      chk("done_not_early", {busy, done}, 2'b10);
      @(negedge clk);
      chk("done_result", {busy, done, pass, fail_cnt}, {2'b01, tbl[t].pass, tbl[t].fail});
`ifdef SKC_FIRST_FAIL_CAPTURE_EN
      chk("first_fail", {first_fail_valid, first_fail_vec}, {tbl[t].ffv, tbl[t].ffvec});
`endif
      abort = 1'b1;
      repeat (4) @(negedge clk);
      abort = 1'b0;
      chk("done_hold", {busy, done, pass, fail_cnt, sk_in, phi_vec},
          {2'b01, tbl[t].pass, tbl[t].fail, 8'hFF, skf(mode, 8'hFF), 8'hFF});
    end

    // start during sweep ignored; async reset at vec 0x80
    mode = 0;
    do_start();
    run_cycles(0, 64 * P + 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored", {busy, done, sk_in}, {2'b10, 8'h40});
    run_cycles(64 * P + 3, 128 * P);
    @(negedge clk);
    chk("at_vec80", {busy, sk_in}, {1'b1, 8'h80});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {sk_in, phi_vec, fail_cnt, busy, done, pass}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("reset_needs_start", {busy, done, sk_in}, {2'b00, 8'h00});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
